vending_multi: RTL and testbench
================================

# vending_multi

Parametrised vending controller for the machine datapath. It accumulates coin credit, stores a per-slot stock count, and validates a selection against a per-slot price bus. On a successful vend it pulses dispense, then returns change greedily, one coin per cycle. It supersedes the fixed seven-slot controller, adding configurable slot count, overflow-protected credit, stock tracking, cancel/refund and an optional card-payment path.

## Interface
- NUM_SLOTS, 7: number of product slots.
- PRICE_W, 10: width of one slot price, in cents.
- CREDIT_W, 10: credit register width. Must hold MAX_CREDIT.
- MAX_CREDIT, 500: credit ceiling, in cents.
- STOCK_W, 4: per-slot stock counter width.
- Clock and reset: one clock, `clk`; reset `rst_n`, synchronous, active-low.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- nickel, dime, quarter, dollar  in  1 each  single-cycle coin pulses worth 5, 10, 25 and 100 cents.
- select  in  1  single-cycle selection request.
- sel_idx  in  $clog2(NUM_SLOTS)  requested slot.
- cancel  in  1  refund request.
- price  in  NUM_SLOTS*PRICE_W  slot s occupies bits [s*PRICE_W +: PRICE_W]. Price 0 means empty slot. Prices are multiples of 5.
- restock, restock_idx, restock_cnt  in  1 / $clog2(NUM_SLOTS) / STOCK_W  load stock for a slot.
- pay_card, card_ok  in  1 each  card payment qualifiers; used only with VEND_CARD_EN.
- credit  out  CREDIT_W  current credit.
- busy  out  1  high while not in IDLE.
- dispensed  out  1  one-cycle vend pulse.
- disp_idx  out  $clog2(NUM_SLOTS)  slot vended, valid with dispensed.
- sold_out, insufficient, coin_reject  out  1 each  one-cycle status pulses.
- chg_valid  out  1  one change coin this cycle.
- chg_coin  out  2  coin code: 0 = nickel, 1 = dime, 2 = quarter.

## Operation
- States: IDLE, CHANGE.
- Coins in IDLE:
  - Values of all coin pulses asserted in the same cycle are summed.
  - If credit + sum ≤ MAX_CREDIT, the sum is added to credit.
  - Otherwise the whole cycle's coins are rejected: coin_reject pulses and credit is unchanged.
- Select in IDLE is evaluated against credit before this cycle's coins. Any coins in a select cycle are rejected. Checks, in priority order:
  - sel_idx ≥ NUM_SLOTS, stock 0 or price 0: sold_out pulses; nothing else changes.
  - credit < price: insufficient pulses.
  - Otherwise: dispensed pulses, disp_idx = sel_idx, stock decrements, and credit becomes credit − price. If the remainder is > 0, go to CHANGE; else stay in IDLE.
- cancel in IDLE:
  - cancel takes priority over select and coins in the same cycle.
  - Credit > 0: go to CHANGE with the full credit.
  - Credit 0: no effect.
- CHANGE, one coin per cycle:
  - Emit the largest of 25/10/5 that is ≤ credit; subtract it from credit.
  - When credit reaches 0, return to IDLE.
  - Coins inserted in CHANGE assert coin_reject. select and cancel are ignored.
- restock is accepted only in IDLE without a simultaneous select: stock[restock_idx] = restock_cnt. Otherwise it is ignored.
- Reset mid-CHANGE aborts: remaining credit is discarded.

## Timing
- Reset values: credit 0; state IDLE; all stock 0; busy, dispensed, disp_idx, sold_out, insufficient, coin_reject, chg_valid and chg_coin all 0.
- All outputs are registered.
- Coin sampled at edge k: credit is visible after edge k; coin_reject is high for the cycle after edge k.
- Select sampled at edge k: status or dispensed pulse is high for one cycle after edge k. busy rises after edge k when change is due.
- First chg_valid appears after edge k+1; one coin per following cycle. busy falls with the edge that emits the last coin.
- Change latency equals the greedy coin count. Example: 60 cents = 25, 25, 10 → 3 cycles.

## Configuration
- Macro: VEND_CARD_EN.
- Defined:
  - select with pay_card = 1 and card_ok = 1 vends without checking or touching credit: dispensed pulses and there is no CHANGE phase.
  - pay_card = 1 with card_ok = 0 pulses insufficient.
  - Sold-out checks still apply first.
- Undefined: pay_card and card_ok are ignored; every vend uses coin credit.

## Test plan
- Reset held 2 cycles → all outputs 0, credit 0, busy 0.
- 4 nickels, restock slot 2 = 3, price[2] = 100, select 2 → insufficient pulse, credit 20. Then cancel → chg_coin 1, 1 (two dimes), busy low, credit 0.
- dollar + quarter (125), price[1] = 65, stock 1, select 1 → dispensed with disp_idx 1, stock[1] = 0, change 25, 25, 10. Then select 1 again → sold_out.
- 5 dollars (500), then a nickel → coin_reject, credit stays 500. A quarter during CHANGE → coin_reject.
- Nickel and select in the same cycle with credit 100, price 100 → vend with no change; nickel rejected; credit 0.
- VEND_CARD_EN: credit 30, pay_card = 1, card_ok = 1, select an in-stock slot → dispensed, credit stays 30, no chg_valid.

Source files
------------

// File: rtl/vending_multi_if.sv
// vending_multi_if -- signal bundle between the machine datapath and the
// vending controller.
//
// Handshake semantics: there is no valid/ready pair. Every request input
// (coin pulses, select, cancel, restock) is a single-cycle strobe. The
// controller samples it on the rising edge and never stalls the sender.
// While busy is high, select and cancel are dropped and coins are bounced
// with coin_reject. Every output is registered. dispensed, sold_out,
// insufficient, coin_reject and chg_valid are one-cycle pulses. disp_idx and
// chg_coin read 0 whenever their qualifying pulse is low.
//
// Modports:
//   master - the datapath side; drives coins, select/sel_idx, cancel, price,
//            restock*, pay_card and card_ok.
//   slave  - the controller side; drives credit, busy, dispensed/disp_idx,
//            the status pulses, chg_valid/chg_coin and state_dbg.
// state_dbg is 0 in IDLE and 1 in CHANGE. It is there for observation only.
interface vending_multi_if #(
  parameter int NUM_SLOTS = 7,
  parameter int PRICE_W   = 10,
  parameter int CREDIT_W  = 10,
  parameter int STOCK_W   = 4
);
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                          nickel;
  logic                          dime;
  logic                          quarter;
  logic                          dollar;
  logic                          select;
  logic [IDX_W-1:0]              sel_idx;
  logic                          cancel;
  logic [NUM_SLOTS*PRICE_W-1:0]  price;
  logic                          restock;
  logic [IDX_W-1:0]              restock_idx;
  logic [STOCK_W-1:0]            restock_cnt;
  logic                          pay_card;
  logic                          card_ok;

  logic [CREDIT_W-1:0]           credit;
  logic                          busy;
  logic                          dispensed;
  logic [IDX_W-1:0]              disp_idx;
  logic                          sold_out;
  logic                          insufficient;
  logic                          coin_reject;
  logic                          chg_valid;
  logic [1:0]                    chg_coin;
  logic                          state_dbg;

  modport master (
    output nickel, dime, quarter, dollar, select, sel_idx, cancel, price,
           restock, restock_idx, restock_cnt, pay_card, card_ok,
    input  credit, busy, dispensed, disp_idx, sold_out, insufficient,
           coin_reject, chg_valid, chg_coin, state_dbg
  );

  modport slave (
    input  nickel, dime, quarter, dollar, select, sel_idx, cancel, price,
           restock, restock_idx, restock_cnt, pay_card, card_ok,
    output credit, busy, dispensed, disp_idx, sold_out, insufficient,
           coin_reject, chg_valid, chg_coin, state_dbg
  );
endinterface

// File: rtl/vending_multi.sv
// vending_multi -- parametrised vending controller.
//
// The controller accumulates coin credit up to MAX_CREDIT and keeps a stock
// count for each slot. It checks a selection against the per-slot price bus.
// A successful vend pulses dispensed. Any remaining credit is then returned
// as change, one greedy coin (25/10/5) per cycle, in the CHANGE state. A
// cancel with nonzero credit returns the full credit the same way.
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - vending_multi_if.slave (coins, select, cancel, price, restock,
//           card qualifiers in; credit, status pulses, change out)
//
// Optional feature: define VEND_CARD_EN to enable card payment. With it
// defined, a select with pay_card vends on card_ok without touching credit.
// Without it, pay_card and card_ok are ignored.
module vending_multi #(
  parameter int NUM_SLOTS  = 7,
  parameter int PRICE_W    = 10,
  parameter int CREDIT_W   = 10,
  parameter int MAX_CREDIT = 500,
  parameter int STOCK_W    = 4
) (
  input logic            clk,
  input logic            rst_n,
  vending_multi_if.slave bus
);
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  // The two extra bits let credit plus a full cycle of coins be compared
  // against the ceiling without wrapping.
  localparam int SW    = CREDIT_W + 2;

  typedef enum logic {IDLE = 1'b0, CHANGE = 1'b1} state_t;

  state_t              state;
  logic [CREDIT_W-1:0] credit_q;
  logic [STOCK_W-1:0]  stock [NUM_SLOTS];
  logic                busy_q, dispensed_q, sold_out_q, insufficient_q;
  logic                coin_reject_q, chg_valid_q;
  logic [IDX_W-1:0]    disp_idx_q;
  logic [1:0]          chg_coin_q;

  logic [SW-1:0]       coin_sum, credit_ext, coin_total, price_ext;
  logic [SW-1:0]       change_val, credit_left;
  logic [PRICE_W-1:0]  sel_price;
  logic [STOCK_W-1:0]  sel_stock;
  logic [1:0]          chg_code;
  logic                any_coin;

  always_comb begin
    coin_sum = '0;
    if (bus.nickel)  coin_sum = coin_sum + SW'(5);
    if (bus.dime)    coin_sum = coin_sum + SW'(10);
    if (bus.quarter) coin_sum = coin_sum + SW'(25);
    if (bus.dollar)  coin_sum = coin_sum + SW'(100);
    any_coin   = bus.nickel | bus.dime | bus.quarter | bus.dollar;
    credit_ext = SW'(credit_q);
    coin_total = credit_ext + coin_sum;

    // An out-of-range sel_idx matches no slot. It then reads price 0 and
    // stock 0, which the sold-out check catches.
    sel_price = '0;
    sel_stock = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (int'(bus.sel_idx) == s) begin
        sel_price = bus.price[s*PRICE_W +: PRICE_W];
        sel_stock = stock[s];
      end
    end
    price_ext = SW'(sel_price);

    // Greedy change coin for the current credit.
    if (credit_ext >= SW'(25)) begin
      chg_code   = 2'd2;
      change_val = SW'(25);
    end else if (credit_ext >= SW'(10)) begin
      chg_code   = 2'd1;
      change_val = SW'(10);
    end else begin
      chg_code   = 2'd0;
      change_val = SW'(5);
    end
    // Clamp so a stray sub-nickel remainder still drains to zero.
    credit_left = (credit_ext > change_val) ? credit_ext - change_val : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      credit_q       <= '0;
      busy_q         <= 1'b0;
      dispensed_q    <= 1'b0;
      disp_idx_q     <= '0;
      sold_out_q     <= 1'b0;
      insufficient_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      chg_valid_q    <= 1'b0;
      chg_coin_q     <= 2'd0;
      for (int s = 0; s < NUM_SLOTS; s++) stock[s] <= '0;
    end else begin
      dispensed_q    <= 1'b0;
      disp_idx_q     <= '0;
      sold_out_q     <= 1'b0;
      insufficient_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      chg_valid_q    <= 1'b0;
      chg_coin_q     <= 2'd0;
      case (state)
        IDLE: begin
          if (bus.restock && !bus.select) begin
            for (int s = 0; s < NUM_SLOTS; s++)
              if (int'(bus.restock_idx) == s) stock[s] <= bus.restock_cnt;
          end
          if (bus.cancel) begin
            // Cancel owns the cycle. Coins arriving with it are bounced.
            coin_reject_q <= any_coin;
            if (credit_q != '0) begin
              state  <= CHANGE;
              busy_q <= 1'b1;
            end
          end else if (bus.select) begin
            coin_reject_q <= any_coin;
            if (sel_stock == '0 || sel_price == '0) begin
              sold_out_q <= 1'b1;
`ifdef VEND_CARD_EN
            end else if (bus.pay_card) begin
              if (bus.card_ok) begin
                dispensed_q <= 1'b1;
                disp_idx_q  <= bus.sel_idx;
                for (int s = 0; s < NUM_SLOTS; s++)
                  if (int'(bus.sel_idx) == s) stock[s] <= stock[s] - 1'b1;
              end else begin
                insufficient_q <= 1'b1;
              end
`endif
            end else if (credit_ext < price_ext) begin
              insufficient_q <= 1'b1;
            end else begin
              dispensed_q <= 1'b1;
              disp_idx_q  <= bus.sel_idx;
              credit_q    <= CREDIT_W'(credit_ext - price_ext);
              for (int s = 0; s < NUM_SLOTS; s++)
                if (int'(bus.sel_idx) == s) stock[s] <= stock[s] - 1'b1;
              if (credit_ext != price_ext) begin
                state  <= CHANGE;
                busy_q <= 1'b1;
              end
            end
          end else if (any_coin) begin
            if (coin_total <= SW'(MAX_CREDIT)) credit_q <= CREDIT_W'(coin_total);
            else coin_reject_q <= 1'b1;
          end
        end
        CHANGE: begin
          coin_reject_q <= any_coin;
          chg_valid_q   <= 1'b1;
          chg_coin_q    <= chg_code;
          credit_q      <= CREDIT_W'(credit_left);
          if (credit_left == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef VEND_CARD_EN
  logic unused_card;
  assign unused_card = bus.pay_card ^ bus.card_ok;
`endif

  assign bus.credit       = credit_q;
  assign bus.busy         = busy_q;
  assign bus.dispensed    = dispensed_q;
  assign bus.disp_idx     = disp_idx_q;
  assign bus.sold_out     = sold_out_q;
  assign bus.insufficient = insufficient_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.chg_valid    = chg_valid_q;
  assign bus.chg_coin     = chg_coin_q;
  assign bus.state_dbg    = (state == CHANGE);
endmodule

// File: tb/tb_vending_multi.sv
// tb_vending_multi -- self-checking bench for vending_multi.
// Each table row drives one cycle of inputs. The expected outputs for the
// cycle after that edge go onto exp_q. They are compared #1 after the edge.
// A hand-written sequence checks a long greedy change run against a model.
module tb_vending_multi;
  localparam logic [3:0] N = 4'b0001, D = 4'b0010, Q = 4'b0100, L = 4'b1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vending_multi_if #(.NUM_SLOTS(7), .PRICE_W(10), .CREDIT_W(10), .STOCK_W(4)) bus();

  vending_multi #(.NUM_SLOTS(7), .PRICE_W(10), .CREDIT_W(10), .MAX_CREDIT(500),
                  .STOCK_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] coins;   // {dollar, quarter, dime, nickel}
    logic       sel;
    logic [2:0] idx;
    logic       can;
    logic       rs;
    logic [2:0] rsi;
    logic [3:0] rsc;
    logic       card;
    logic       cok;
    logic [20:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [20:0] exp_q[$];
  string       name_q[$];
  logic [1:0]  chg_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [20:0] pack(logic [9:0] cr, logic b, logic d, logic [2:0] di,
                                       logic so, logic ins, logic rj, logic cv, logic [1:0] cc);
    return {cr, b, d, di, so, ins, rj, cv, cc};
  endfunction

  function automatic void v(string nm, logic rst, logic [3:0] coins, logic sel,
                            logic [2:0] idx, logic can, logic rs, logic [2:0] rsi,
                            logic [3:0] rsc, logic card, logic cok, logic [20:0] e);
    vec_t x;
    x.name = nm; x.rst = rst; x.coins = coins; x.sel = sel; x.idx = idx; x.can = can;
    x.rs = rs; x.rsi = rsi; x.rsc = rsc; x.card = card; x.cok = cok; x.exp = e;
    vecs.push_back(x);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic drive_idle();
    {bus.dollar, bus.quarter, bus.dime, bus.nickel} = 4'b0;
    bus.select = 1'b0; bus.sel_idx = '0; bus.cancel = 1'b0;
    bus.restock = 1'b0; bus.restock_idx = '0; bus.restock_cnt = '0;
    bus.pay_card = 1'b0; bus.card_ok = 1'b0;
  endtask

  task automatic apply(vec_t x);
    logic [20:0] act;
    @(negedge clk);
    rst_n = ~x.rst;
    {bus.dollar, bus.quarter, bus.dime, bus.nickel} = x.coins;
    bus.select = x.sel; bus.sel_idx = x.idx; bus.cancel = x.can;
    bus.restock = x.rs; bus.restock_idx = x.rsi; bus.restock_cnt = x.rsc;
    bus.pay_card = x.card; bus.card_ok = x.cok;
    exp_q.push_back(x.exp);
    name_q.push_back(x.name);
    @(posedge clk);
    #1;
    act = pack(bus.credit, bus.busy, bus.dispensed, bus.disp_idx, bus.sold_out,
               bus.insufficient, bus.coin_reject, bus.chg_valid, bus.chg_coin);
    check(name_q.pop_front(), 32'(act), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int model_credit;
    drive_idle();
    // slot: 0=50 1=65 2=100 3=100 4=empty 5=35 6=20
    bus.price = {10'd20, 10'd35, 10'd0, 10'd100, 10'd100, 10'd65, 10'd50};

    //  name            rst coins sel idx can rs rsi rsc card cok  {cr, b, d, di, so, in, rj, cv, cc}
    v("rst0",          1, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,0,0,0,0,0));
    v("rst1",          1, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,0,0,0,0,0));
    v("n1",            0, N,     0, 0, 0, 0, 0, 0, 0, 0, pack(5,   0,0,0,0,0,0,0,0));
    v("n2",            0, N,     0, 0, 0, 0, 0, 0, 0, 0, pack(10,  0,0,0,0,0,0,0,0));
    v("n3",            0, N,     0, 0, 0, 0, 0, 0, 0, 0, pack(15,  0,0,0,0,0,0,0,0));
    v("n4",            0, N,     0, 0, 0, 0, 0, 0, 0, 0, pack(20,  0,0,0,0,0,0,0,0));
    v("rs2",           0, 0,     0, 0, 0, 1, 2, 3, 0, 0, pack(20,  0,0,0,0,0,0,0,0));
    v("sel2_insuf",    0, 0,     1, 2, 0, 0, 0, 0, 0, 0, pack(20,  0,0,0,0,1,0,0,0));
    v("cancel20",      0, 0,     0, 0, 1, 0, 0, 0, 0, 0, pack(20,  1,0,0,0,0,0,0,0));
    v("chg_dime1",     0, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(10,  1,0,0,0,0,0,1,1));
    v("chg_dime2",     0, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,0,0,0,1,1));
    v("idle_a",        0, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,0,0,0,0,0));
    v("dollar_qtr",    0, L|Q,   0, 0, 0, 0, 0, 0, 0, 0, pack(125, 0,0,0,0,0,0,0,0));
    v("rs1",           0, 0,     0, 0, 0, 1, 1, 1, 0, 0, pack(125, 0,0,0,0,0,0,0,0));
    v("sel1_vend",     0, 0,     1, 1, 0, 0, 0, 0, 0, 0, pack(60,  1,1,1,0,0,0,0,0));
    v("chg_q1",        0, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(35,  1,0,0,0,0,0,1,2));
    v("chg_q2",        0, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(10,  1,0,0,0,0,0,1,2));
    v("chg_d",         0, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,0,0,0,1,1));
    v("sel1_sold",     0, 0,     1, 1, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,1,0,0,0,0));
    v("l1",            0, L,     0, 0, 0, 0, 0, 0, 0, 0, pack(100, 0,0,0,0,0,0,0,0));
    v("l2",            0, L,     0, 0, 0, 0, 0, 0, 0, 0, pack(200, 0,0,0,0,0,0,0,0));
    v("l3",            0, L,     0, 0, 0, 0, 0, 0, 0, 0, pack(300, 0,0,0,0,0,0,0,0));
    v("l4",            0, L,     0, 0, 0, 0, 0, 0, 0, 0, pack(400, 0,0,0,0,0,0,0,0));
    v("l5_at_max",     0, L,     0, 0, 0, 0, 0, 0, 0, 0, pack(500, 0,0,0,0,0,0,0,0));
    v("n_over",        0, N,     0, 0, 0, 0, 0, 0, 0, 0, pack(500, 0,0,0,0,0,1,0,0));
    v("qd_over",       0, Q|D,   0, 0, 0, 0, 0, 0, 0, 0, pack(500, 0,0,0,0,0,1,0,0));
    v("cancel500",     0, 0,     0, 0, 1, 0, 0, 0, 0, 0, pack(500, 1,0,0,0,0,0,0,0));
    v("qtr_in_chg",    0, Q,     0, 0, 0, 0, 0, 0, 0, 0, pack(475, 1,0,0,0,0,1,1,2));
    v("sel_in_chg",    0, 0,     1, 1, 1, 0, 0, 0, 0, 0, pack(450, 1,0,0,0,0,0,1,2));
    v("rst_abort",     1, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,0,0,0,0,0));
    v("idle_post_rst", 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,0,0,0,0,0));
    v("stock_cleared", 0, 0,     1, 2, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,1,0,0,0,0));
    v("l100",          0, L,     0, 0, 0, 0, 0, 0, 0, 0, pack(100, 0,0,0,0,0,0,0,0));
    v("rs3",           0, 0,     0, 0, 0, 1, 3, 2, 0, 0, pack(100, 0,0,0,0,0,0,0,0));
    v("n_sel3_exact",  0, N,     1, 3, 0, 0, 0, 0, 0, 0, pack(0,   0,1,3,0,0,1,0,0));
    v("idle_no_chg",   0, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,0,0,0,0,0));
    v("rs5_with_sel",  0, 0,     1, 5, 0, 1, 5, 5, 0, 0, pack(0,   0,0,0,1,0,0,0,0));
    v("sel5_still_0",  0, 0,     1, 5, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,1,0,0,0,0));
    v("sel7_range",    0, 0,     1, 7, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,1,0,0,0,0));
    v("rs4",           0, 0,     0, 0, 0, 1, 4, 3, 0, 0, pack(0,   0,0,0,0,0,0,0,0));
    v("sel4_price0",   0, 0,     1, 4, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,1,0,0,0,0));
    v("rs5",           0, 0,     0, 0, 0, 1, 5, 2, 0, 0, pack(0,   0,0,0,0,0,0,0,0));
    v("qd35",          0, Q|D,   0, 0, 0, 0, 0, 0, 0, 0, pack(35,  0,0,0,0,0,0,0,0));
    v("sel5_exact",    0, 0,     1, 5, 0, 0, 0, 0, 0, 0, pack(0,   0,1,5,0,0,0,0,0));
    v("rs6",           0, 0,     0, 0, 0, 1, 6, 1, 0, 0, pack(0,   0,0,0,0,0,0,0,0));
    v("qd35b",         0, Q|D,   0, 0, 0, 0, 0, 0, 0, 0, pack(35,  0,0,0,0,0,0,0,0));
    v("sel6_vend",     0, 0,     1, 6, 0, 0, 0, 0, 0, 0, pack(15,  1,1,6,0,0,0,0,0));
    v("chg_dime",      0, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(5,   1,0,0,0,0,0,1,1));
    v("chg_nickel",    0, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(0,   0,0,0,0,0,0,1,0));
    v("cancel_zero",   0, 0,     0, 0, 1, 0, 0, 0, 0, 0, pack(0,   0,0,0,0,0,0,0,0));
    v("qn30",          0, Q|N,   0, 0, 0, 0, 0, 0, 0, 0, pack(30,  0,0,0,0,0,0,0,0));
    v("rs0",           0, 0,     0, 0, 0, 1, 0, 2, 0, 0, pack(30,  0,0,0,0,0,0,0,0));
`ifdef VEND_CARD_EN
    v("card_ok",       0, 0,     1, 0, 0, 0, 0, 0, 1, 1, pack(30,  0,1,0,0,0,0,0,0));
`else
    v("card_ignored",  0, 0,     1, 0, 0, 0, 0, 0, 1, 1, pack(30,  0,0,0,0,1,0,0,0));
`endif
    v("card_declined", 0, 0,     1, 0, 0, 0, 0, 0, 1, 0, pack(30,  0,0,0,0,1,0,0,0));
    v("after_card",    0, 0,     0, 0, 0, 0, 0, 0, 0, 0, pack(30,  0,0,0,0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Long greedy refund: 30 + 140 = 170 = 6 quarters + 2 dimes.
    @(negedge clk);
    drive_idle();
    {bus.dollar, bus.quarter, bus.dime, bus.nickel} = 4'b1111;
    @(posedge clk); #1;
    check("all_coins_170", 32'(bus.credit), 32'd170);
    @(negedge clk);
    drive_idle();
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    check("refund_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    drive_idle();
    model_credit = 170;
    while (model_credit > 0) begin
      if (model_credit >= 25) begin chg_q.push_back(2'd2); model_credit -= 25; end
      else if (model_credit >= 10) begin chg_q.push_back(2'd1); model_credit -= 10; end
      else begin chg_q.push_back(2'd0); model_credit -= 5; end
    end
    cycles = 0;
    while (bus.busy && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (chg_q.size() == 0) begin
        check("refund_extra_coin", 32'(bus.chg_valid), 32'd0);
      end else begin
        check("refund_valid", 32'(bus.chg_valid), 32'd1);
        check("refund_coin", 32'(bus.chg_coin), 32'(chg_q.pop_front()));
      end
    end
    check("refund_cycles", 32'(cycles), 32'd8);
    check("refund_left", 32'(chg_q.size()), 32'd0);
    check("refund_credit0", 32'(bus.credit), 32'd0);
    check("refund_idle", 32'(bus.state_dbg), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
